// File: rtl/msg_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : msg_demux_pkg
//  Purpose  : Shared types and field widths for the serial message demux.
//  Revision : 1.0 - initial release
// ============================================================================
package msg_demux_pkg;

    localparam int PORT_W = 2;          // port-id field width
    localparam int LEN_W  = 6;          // length field width (bytes)
    localparam int CNT_W  = LEN_W + 3;  // payload bit counter width (8*n)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PID  = 2'd1,
        LEN  = 2'd2,
        DATA = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/msg_demux_shreg.sv
`default_nettype none
// ============================================================================
//  Module   : msg_demux_shreg
//  Purpose  : LSB-first serial field capture. Bit k of the field is written
//             on the k-th enabled cycle; o_last flags the final field bit.
//             o_value_nxt shows the field including the bit arriving now.
//  Revision : 1.0 - initial release
// ============================================================================
module msg_demux_shreg
    import msg_demux_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_value,
    output logic [WIDTH-1:0] o_value_nxt,
    output logic             o_last
);

    localparam int               c_cw   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cw-1:0]  c_last = c_cw'(WIDTH - 1);

    logic [c_cw-1:0]  r_cnt;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_value_nxt;

    // Place the incoming bit at the position selected by the bit counter
    always_comb begin
        w_value_nxt = r_value;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_en && (r_cnt == c_cw'(i))) begin
                w_value_nxt[i] = i_bit;
            end
        end
    end

    assign o_last      = i_en && (r_cnt == c_last);
    assign o_value     = r_value;
    assign o_value_nxt = w_value_nxt;

    // Field register and bit counter; the counter wraps after the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_value <= '0;
        end else if (i_en) begin
            r_value <= w_value_nxt;
            r_cnt   <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/msg_serial_demux.sv
`default_nettype none
// ============================================================================
//  Module   : msg_serial_demux
//  Purpose  : Frames a serial stream (start 0, port id, byte length, payload)
//             and steers each payload bit to one of 2**PORT_W serial ports.
//             REG_OUT=0 gives Mealy valid/port/error, REG_OUT=1 flops them.
//  Revision : 1.0 - initial release
// ============================================================================
module msg_serial_demux #(
    parameter int REG_OUT = 0,
    parameter int PORT_W  = msg_demux_pkg::PORT_W,
    parameter int LEN_W   = msg_demux_pkg::LEN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sIn,
    output logic                     valid,
    output logic                     error,
    output logic [PORT_W-1:0]        d,
    output logic [(1<<PORT_W)-1:0]   port
);

    import msg_demux_pkg::*;

    localparam int c_nports = 1 << PORT_W;
    localparam int c_cnt_w  = LEN_W + 3;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;

    logic                w_pid_en;
    logic                w_len_en;
    logic                w_pid_last;
    logic                w_len_last;
    logic [PORT_W-1:0]   w_d;
    logic [PORT_W-1:0]   w_pid_nxt;
    logic [LEN_W-1:0]    w_len_val;
    logic [LEN_W-1:0]    w_n_nxt;
    logic                w_valid;
    logic                w_error;
    logic [c_nports-1:0] w_port;
    logic                w_unused;

    assign w_pid_en = (r_state == PID);
    assign w_len_en = (r_state == LEN);

    msg_demux_shreg #(.WIDTH(PORT_W)) u_pid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_pid_en),
        .i_bit       (sIn),
        .o_value     (w_d),
        .o_value_nxt (w_pid_nxt),
        .o_last      (w_pid_last)
    );

    msg_demux_shreg #(.WIDTH(LEN_W)) u_len (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_len_en),
        .i_bit       (sIn),
        .o_value     (w_len_val),
        .o_value_nxt (w_n_nxt),
        .o_last      (w_len_last)
    );

    // Only the registered port id and the in-flight length are consumed
    assign w_unused = ^{w_pid_nxt, w_len_val};

    assign d       = w_d;
    assign w_valid = (r_state == DATA);
    assign w_error = w_len_en && w_len_last && (w_n_nxt == '0);
    assign w_port  = w_valid ? (c_nports'(sIn) << w_d) : '0;

    // Framing FSM with the payload bit down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!sIn) begin
                        r_state <= PID;
                    end
                end
                PID: begin
                    if (w_pid_last) begin
                        r_state <= LEN;
                    end
                end
                LEN: begin
                    if (w_len_last) begin
                        if (w_n_nxt == '0) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= {w_n_nxt, 3'b000};
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic                r_valid;
            logic                r_error;
            logic [c_nports-1:0] r_port;

            // Output stage delaying valid, port and error by one cycle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_error <= 1'b0;
                    r_port  <= '0;
                end else begin
                    r_valid <= w_valid;
                    r_error <= w_error;
                    r_port  <= w_port;
                end
            end

            assign valid = r_valid;
            assign error = r_error;
            assign port  = r_port;
        end else begin : g_comb_out
            assign valid = w_valid;
            assign error = w_error;
            assign port  = w_port;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_msg_serial_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msg_serial_demux
//  Purpose  : Scoreboard bench driving one serial stream into a Mealy
//             (REG_OUT=0) and a registered (REG_OUT=1) demux side by side.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_msg_serial_demux;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sIn   = 1'b1;

    logic       valid0, error0, valid1, error1;
    logic [1:0] d0, d1;
    logic [3:0] port0, port1;

    msg_serial_demux #(.REG_OUT(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .sIn   (sIn),
        .valid (valid0),
        .error (error0),
        .d     (d0),
        .port  (port0)
    );

    msg_serial_demux #(.REG_OUT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .sIn   (sIn),
        .valid (valid1),
        .error (error1),
        .d     (d1),
        .port  (port1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         c;
        logic [1:0] p;
        logic       b;
    } exp_t;

    exp_t bq[2][$];   // expected payload bits per instance, tagged with cycle
    int   eq[2][$];   // expected error-pulse cycles per instance

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc=%0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic e,
                       input logic [1:0] dd, input logic [3:0] pp);
        exp_t x;
        bit   ev;
        bit   ee;
        ev = (bq[k].size() > 0) && (bq[k][0].c == cyc);
        chk("valid", k, int'(v), int'(ev));
        if (ev) begin
            x = bq[k].pop_front();
            chk("d", k, int'(dd), int'(x.p));
            chk("port", k, int'(pp), int'(4'(x.b) << x.p));
        end else begin
            chk("port_quiet", k, int'(pp), 0);
        end
        ee = (eq[k].size() > 0) && (eq[k][0] == cyc);
        chk("error", k, int'(e), int'(ee));
        if (ee) void'(eq[k].pop_front());
        if (!rst_n) chk("d_reset", k, int'(dd), 0);
    endtask

    always @(negedge clk) begin
        mon(0, valid0, error0, d0, port0);
        mon(1, valid1, error1, d1, port1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        tick();
        sIn = b;
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b1);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        sIn   = 1'b1;
        bq[0].delete();
        bq[1].delete();
        eq[0].delete();
        eq[1].delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // abort_at >= 0 pulses reset in place of payload bit number abort_at
    task automatic send_packet(input logic [1:0] p, input logic [5:0] n,
                               input logic [7:0] seed, input int abort_at);
        logic [7:0] by;
        logic       b;
        exp_t       x;
        send(1'b0);
        for (int i = 0; i < 2; i++) send(p[i]);
        for (int i = 0; i < 6; i++) begin
            send(n[i]);
            if (i == 5 && n == 6'd0) begin
                eq[0].push_back(cyc);
                eq[1].push_back(cyc + 1);
            end
        end
        for (int i = 0; i < 8 * int'(n); i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            by = seed + 8'(37 * (i / 8));
            b  = by[i % 8];
            send(b);
            x.c = cyc;     x.p = p; x.b = b; bq[0].push_back(x);
            x.c = cyc + 1;                   bq[1].push_back(x);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sIn   = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        idle(10);

        send_packet(2'd2, 6'd3, 8'hA5, -1);
        idle(2);
        send_packet(2'd0, 6'd1, 8'h3C, -1);
        idle(1);
        send_packet(2'd1, 6'd1, 8'hC3, -1);
        idle(1);
        send_packet(2'd3, 6'd1, 8'h96, -1);
        idle(2);

        send_packet(2'd1, 6'd0, 8'h00, -1);
        idle(3);

        send_packet(2'd3, 6'd1, 8'h0F, -1);
        send_packet(2'd0, 6'd2, 8'hF0, -1);
        idle(2);

        send_packet(2'd2, 6'd2, 8'h5A, 5);
        idle(2);
        send_packet(2'd1, 6'd1, 8'h81, -1);
        idle(2);

        send_packet(2'd3, 6'd63, 8'h11, -1);
        idle(5);

        chk("leftover_bits", 0, bq[0].size(), 0);
        chk("leftover_bits", 1, bq[1].size(), 0);
        chk("leftover_errs", 0, eq[0].size(), 0);
        chk("leftover_errs", 1, eq[1].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
